// File: rtl/lcd_16207_pkg.sv
// Shared constants, opcode masks, FSM states and address-counter helpers
// for the 16207 panel-side responder.
package lcd_16207_pkg;

   localparam int         DDRAM_DEPTH = 80;
   localparam int         LINE_LEN    = 40;
   localparam logic [6:0] LINE2_BASE  = 7'h40;
   localparam logic [7:0] SPACE       = 8'h20;

   localparam logic [6:0] LINE1_LAST  = 7'(LINE_LEN - 1);
   localparam logic [6:0] LINE2_LAST  = LINE2_BASE + LINE1_LAST;

   localparam logic [7:0] OP_CLEAR    = 8'h01;
   localparam logic [7:0] OP_HOME     = 8'h02;
   localparam logic [7:0] OP_ENTRY    = 8'h04;
   localparam logic [7:0] OP_DISPLAY  = 8'h08;
   localparam logic [7:0] OP_SHIFT    = 8'h10;
   localparam logic [7:0] OP_FUNC     = 8'h20;
   localparam logic [7:0] OP_CGRAM    = 8'h40;
   localparam logic [7:0] OP_DDRAM    = 8'h80;

   typedef enum logic [2:0] {
      ST_INIT_CLR,
      ST_IDLE,
      ST_EXEC,
      ST_CLR_FILL,
      ST_BUSY_WAIT
   } state_t;

   function automatic logic ac_valid(input logic [6:0] ac);
      return {1'b0, ac[5:0]} < 7'(LINE_LEN);
   endfunction

   function automatic logic [6:0] ac_to_index(input logic [6:0] ac);
      return ac[6] ? 7'(LINE_LEN) + {1'b0, ac[5:0]} : {1'b0, ac[5:0]};
   endfunction

   // Line ends wrap to the other line; invalid gaps step in plain binary.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] r;
      if (inc)
         r = (ac == LINE1_LAST) ? LINE2_BASE : (ac == LINE2_LAST) ? 7'h00 : ac + 7'd1;
      else
         r = (ac == 7'h00) ? LINE2_LAST : (ac == LINE2_BASE) ? LINE1_LAST : ac - 7'd1;
      return r;
   endfunction

endpackage

// File: rtl/lcd_16207_responder_ddram.sv
// 80x8 DDRAM shadow: port A write/read owned by the responder FSM,
// port B read-only for the display overlay. Both reads are registered.
module lcd_ddram_80x8
   import lcd_16207_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we_a,
   input  logic [6:0] addr_a,
   input  logic [7:0] wdata_a,
   output logic [7:0] q_a,
   input  logic [6:0] addr_b,
   output logic [7:0] q_b
);

   logic [7:0] mem [DDRAM_DEPTH];

   always_ff @(posedge clk) begin
      if (we_a) begin
         if (addr_a < 7'(DDRAM_DEPTH))
            mem[addr_a] <= wdata_a;
      end else if (addr_a < 7'(DDRAM_DEPTH)) begin
         q_a <= mem[addr_a];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q_b <= 8'h00;
      else if (addr_b < 7'(DDRAM_DEPTH))
         q_b <= mem[addr_b];
      else
         q_b <= 8'h00;
   end

endmodule

// File: rtl/lcd_16207_responder.sv
// HD44780-style panel responder: samples the 16207 bus, executes instructions
// against a DDRAM shadow and answers status/data reads on the shared data bus.
module lcd_16207_responder
   import lcd_16207_pkg::*;
#(
   parameter int CMD_CYCLES   = 2000,
   parameter int HOME_CYCLES  = 82000,
   parameter int CLEAR_CYCLES = 82000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   inout  wire  [7:0] LCD_data,
   input  logic       err_clr,
   input  logic [6:0] ddram_rd_addr,
   output logic [7:0] ddram_rd_data,
   output logic       busy,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       err_overrun
);

   logic       e_p0, e_p1, e_p2;
   logic       rs_p0, rs_p1;
   logic       rw_p0, rw_p1;
   logic [7:0] data_p0, data_p1;

   logic       cmd_rs, cmd_rw;
   logic [7:0] cmd_byte;

   state_t     state, state_n;
   logic [6:0] ac, ac_n;
   logic       id, id_n;
   logic       disp_n, cursor_n, blink_n;
   logic       cg_mode, cg_mode_n;
   logic [31:0] cnt, cnt_n;
   logic [6:0] fill, fill_n;

   logic       ram_we;
   logic [6:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] prefetch;

   logic       e_fall, err_set, drive_en;
   logic [7:0] rd_byte;

   // Bus synchroniser stage: E/RS/RW/data through two flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_p0  <= 1'b0;
         e_p1  <= 1'b0;
         e_p2  <= 1'b0;
         rs_p0 <= 1'b0;
         rs_p1 <= 1'b0;
         rw_p0 <= 1'b0;
         rw_p1 <= 1'b0;
      end else begin
         e_p0  <= LCD_E;
         e_p1  <= e_p0;
         e_p2  <= e_p1;
         rs_p0 <= LCD_RS;
         rs_p1 <= rs_p0;
         rw_p0 <= LCD_RW;
         rw_p1 <= rw_p0;
      end
   end

   always_ff @(posedge clk) begin
      data_p0 <= LCD_data;
      data_p1 <= data_p0;
   end

   // Latch stage: the cycle before the synced E fall holds the committed values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_rs <= 1'b0;
         cmd_rw <= 1'b0;
      end else if (e_p1) begin
         cmd_rs <= rs_p1;
         cmd_rw <= rw_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (e_p1)
         cmd_byte <= data_p1;
   end

   assign e_fall  = e_p2 & ~e_p1;
   assign busy    = (state != ST_IDLE);
   assign err_set = e_fall & busy & (~cmd_rw | cmd_rs);

   always_comb begin
      state_n   = state;
      ac_n      = ac;
      id_n      = id;
      disp_n    = disp_on;
      cursor_n  = cursor_on;
      blink_n   = blink_on;
      cg_mode_n = cg_mode;
      cnt_n     = cnt;
      fill_n    = fill;
      ram_we    = 1'b0;
      ram_addr  = ac_valid(ac) ? ac_to_index(ac) : 7'd0;
      ram_wdata = cmd_byte;

      case (state)
         ST_INIT_CLR: begin
            ram_we    = 1'b1;
            ram_addr  = fill;
            ram_wdata = SPACE;
            if (fill == 7'(DDRAM_DEPTH - 1)) begin
               fill_n  = 7'd0;
               state_n = ST_IDLE;
            end else begin
               fill_n = fill + 7'd1;
            end
         end

         ST_IDLE: begin
            if (e_fall) begin
               if (!cmd_rw)
                  state_n = ST_EXEC;
               else if (cmd_rs)
                  ac_n = ac_step(ac, id);
            end
         end

         ST_EXEC: begin
            state_n = ST_BUSY_WAIT;
            cnt_n   = 32'(CMD_CYCLES - 2);
            if (cmd_rs) begin
               // CGRAM data and writes into the line gaps are dropped; AC still steps
               ram_we = ~cg_mode & ac_valid(ac);
               ac_n   = ac_step(ac, id);
            end else if (|(cmd_byte & OP_DDRAM)) begin
               ac_n      = cmd_byte[6:0];
               cg_mode_n = 1'b0;
            end else if (|(cmd_byte & OP_CGRAM)) begin
               cg_mode_n = 1'b1;
            end else if (|(cmd_byte & OP_FUNC)) begin
               cg_mode_n = cg_mode;
            end else if (|(cmd_byte & OP_SHIFT)) begin
               if (!cmd_byte[3])
                  ac_n = ac_step(ac, cmd_byte[2]);
            end else if (|(cmd_byte & OP_DISPLAY)) begin
               disp_n   = cmd_byte[2];
               cursor_n = cmd_byte[1];
               blink_n  = cmd_byte[0];
            end else if (|(cmd_byte & OP_ENTRY)) begin
               id_n = cmd_byte[1];
            end else if (|(cmd_byte & OP_HOME)) begin
               ac_n      = 7'd0;
               cg_mode_n = 1'b0;
               cnt_n     = 32'(HOME_CYCLES - 2);
            end else if (|(cmd_byte & OP_CLEAR)) begin
               ac_n      = 7'd0;
               id_n      = 1'b1;
               cg_mode_n = 1'b0;
               fill_n    = 7'd0;
               state_n   = ST_CLR_FILL;
            end
         end

         ST_CLR_FILL: begin
            ram_we    = 1'b1;
            ram_addr  = fill;
            ram_wdata = SPACE;
            if (fill == 7'(DDRAM_DEPTH - 1)) begin
               fill_n = 7'd0;
               // EXEC plus the 80 fill cycles already account for 81 busy cycles
               if (CLEAR_CYCLES > 81) begin
                  state_n = ST_BUSY_WAIT;
                  cnt_n   = 32'(CLEAR_CYCLES - 82);
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               fill_n = fill + 7'd1;
            end
         end

         ST_BUSY_WAIT: begin
            if (cnt == 32'd0)
               state_n = ST_IDLE;
            else
               cnt_n = cnt - 32'd1;
         end

         default: state_n = ST_INIT_CLR;
      endcase
   end

   // Control state stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_INIT_CLR;
         ac          <= 7'd0;
         id          <= 1'b1;
         disp_on     <= 1'b0;
         cursor_on   <= 1'b0;
         blink_on    <= 1'b0;
         cg_mode     <= 1'b0;
         cnt         <= 32'd0;
         fill        <= 7'd0;
         err_overrun <= 1'b0;
      end else begin
         state     <= state_n;
         ac        <= ac_n;
         id        <= id_n;
         disp_on   <= disp_n;
         cursor_on <= cursor_n;
         blink_on  <= blink_n;
         cg_mode   <= cg_mode_n;
         cnt       <= cnt_n;
         fill      <= fill_n;
         if (err_set)
            err_overrun <= 1'b1;
         else if (err_clr)
            err_overrun <= 1'b0;
      end
   end

   lcd_ddram_80x8 u_ddram (
      .clk     (clk),
      .reset   (reset),
      .we_a    (ram_we),
      .addr_a  (ram_addr),
      .wdata_a (ram_wdata),
      .q_a     (prefetch),
      .addr_b  (ddram_rd_addr),
      .q_b     (ddram_rd_data)
   );

   // Read-back stage: status or prefetched data, zero for data reads while busy
   always_comb begin
      rd_byte = {busy, ac};
      if (rs_p1)
         rd_byte = busy ? 8'h00 : prefetch;
   end

   assign drive_en = e_p1 & rw_p1;
   assign LCD_data = drive_en ? rd_byte : 8'hzz;

endmodule

// File: tb/tb_lcd_16207_responder.sv
// Directed bench for lcd_16207_responder: bus master tasks, overlay reads
// and immediate-assertion checks against hand-computed values.
module tb_lcd_16207_responder;

   localparam int CMD  = 20;
   localparam int HOME = 30;
   localparam int CLR  = 100;
   localparam int MAXW = 1000;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       lcd_e   = 1'b0;
   logic       lcd_rs  = 1'b0;
   logic       lcd_rw  = 1'b0;
   logic       err_clr = 1'b0;
   logic [6:0] rd_addr = 7'd0;
   logic [7:0] rd_data;
   logic       busy, disp_on, cursor_on, blink_on, err_overrun;
   logic       tb_oe   = 1'b0;
   logic [7:0] tb_drv  = 8'h00;
   wire  [7:0] lcd_data;

   int checks = 0;
   int errors = 0;

   assign lcd_data = tb_oe ? tb_drv : 8'hzz;

   always #5 clk = ~clk;

   lcd_16207_responder #(
      .CMD_CYCLES   (CMD),
      .HOME_CYCLES  (HOME),
      .CLEAR_CYCLES (CLR)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .LCD_E         (lcd_e),
      .LCD_RS        (lcd_rs),
      .LCD_RW        (lcd_rw),
      .LCD_data      (lcd_data),
      .err_clr       (err_clr),
      .ddram_rd_addr (rd_addr),
      .ddram_rd_data (rd_data),
      .busy          (busy),
      .disp_on       (disp_on),
      .cursor_on     (cursor_on),
      .blink_on      (blink_on),
      .err_overrun   (err_overrun)
   );

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic rs, input logic [7:0] d);
      @(negedge clk);
      lcd_rs = rs;
      lcd_rw = 1'b0;
      tb_drv = d;
      tb_oe  = 1'b1;
      @(negedge clk);
      lcd_e = 1'b1;
      repeat (6) @(negedge clk);
      lcd_e = 1'b0;
      repeat (4) @(posedge clk);
      #1 tb_oe = 1'b0;
   endtask

   task automatic bus_read(input logic rs, output logic [7:0] d);
      @(negedge clk);
      lcd_rs = rs;
      lcd_rw = 1'b1;
      @(negedge clk);
      lcd_e = 1'b1;
      repeat (6) @(negedge clk);
      d = lcd_data;
      lcd_e = 1'b0;
      repeat (4) @(posedge clk);
      #1 lcd_rw = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < MAXW) begin
         @(posedge clk);
         #1 n++;
      end
      check8("idle_timeout", 8'(busy), 8'h00);
   endtask

   task automatic do_write(input logic rs, input logic [7:0] d);
      int n;
      bus_write(rs, d);
      wait_idle(n);
   endtask

   task automatic check_ram(input string tag, input int idx, input logic [7:0] exp);
      @(negedge clk);
      rd_addr = 7'(idx);
      @(negedge clk);
      check8(tag, rd_data, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] rd;

      // 1. Reset state and the initial space fill
      repeat (3) @(negedge clk);
      check8("rst_busy", 8'(busy), 8'h01);
      check8("rst_rd_data", rd_data, 8'h00);
      check8("rst_err", 8'(err_overrun), 8'h00);
      check8("rst_dcb", {5'd0, disp_on, cursor_on, blink_on}, 8'h00);
      reset = 1'b0;
      n = 0;
      while (busy && n < MAXW) begin
         @(posedge clk);
         #1 n++;
      end
      check_int("init_busy_len", n, 80);
      for (int i = 0; i < 80; i++) check_ram("init_space", i, 8'h20);
      check_ram("rd_idx80", 80, 8'h00);
      bus_read(1'b0, rd);
      check8("init_status", rd, 8'h00);

      // 2. End of line 1 wraps into line 2
      bus_write(1'b0, 8'hA7);
      wait_idle(n);
      check_int("cmd_busy_len", n, CMD - 1);
      do_write(1'b1, 8'h41);
      do_write(1'b1, 8'h42);
      check_ram("ram39", 39, 8'h41);
      check_ram("ram40", 40, 8'h42);
      bus_read(1'b0, rd);
      check8("status_wrap_inc", rd, 8'h41);

      // 3. Decrement wrap from AC 0
      do_write(1'b0, 8'h04);
      do_write(1'b0, 8'h80);
      do_write(1'b1, 8'h55);
      check_ram("ram0_dec", 0, 8'h55);
      bus_read(1'b0, rd);
      check8("status_wrap_dec", rd, 8'h67);

      // 4. Write while busy sets the sticky error
      do_write(1'b0, 8'h06);
      do_write(1'b0, 8'h80);
      bus_write(1'b1, 8'h11);
      bus_write(1'b1, 8'h22);
      check8("err_set", 8'(err_overrun), 8'h01);
      wait_idle(n);
      check_ram("ram0_ok", 0, 8'h11);
      check_ram("ram1_kept", 1, 8'h20);
      bus_read(1'b0, rd);
      check8("status_no_step", rd, 8'h01);
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      check8("err_clr", 8'(err_overrun), 8'h00);

      // Cursor shift and return home
      do_write(1'b0, 8'h10);
      do_write(1'b0, 8'h10);
      bus_read(1'b0, rd);
      check8("shift_left_wrap", rd, 8'h67);
      do_write(1'b0, 8'h14);
      bus_read(1'b0, rd);
      check8("shift_right_wrap", rd, 8'h00);
      do_write(1'b0, 8'hC5);
      bus_write(1'b0, 8'h02);
      wait_idle(n);
      check_int("home_busy_len", n, HOME - 1);
      bus_read(1'b0, rd);
      check8("home_status", rd, 8'h00);

      // 5. Fill every cell, then Clear Display
      for (int i = 0; i < 80; i++) do_write(1'b1, 8'(8'h80 + i));
      check_ram("fill0", 0, 8'h80);
      check_ram("fill40", 40, 8'hA8);
      check_ram("fill79", 79, 8'hCF);
      do_write(1'b0, 8'h04);
      bus_write(1'b0, 8'h01);
      wait_idle(n);
      check_int("clear_busy_len", n, CLR - 1);
      for (int i = 0; i < 80; i++) check_ram("clear_space", i, 8'h20);
      bus_read(1'b0, rd);
      check8("clear_status", rd, 8'h00);
      do_write(1'b1, 8'h33);
      bus_read(1'b0, rd);
      check8("clear_sets_inc", rd, 8'h01);

      // 6. Display control, data read through the prefetch
      do_write(1'b0, 8'h0F);
      check8("disp_on", 8'(disp_on), 8'h01);
      check8("cursor_on", 8'(cursor_on), 8'h01);
      check8("blink_on", 8'(blink_on), 8'h01);
      do_write(1'b0, 8'hC0);
      do_write(1'b1, 8'h5A);
      do_write(1'b0, 8'hC0);
      bus_read(1'b1, rd);
      check8("data_read", rd, 8'h5A);
      bus_read(1'b0, rd);
      check8("status_after_read", rd, 8'h41);

      // Data read while busy returns zero and flags the error
      bus_write(1'b0, 8'hC0);
      bus_read(1'b1, rd);
      check8("busy_read_zero", rd, 8'h00);
      check8("busy_read_err", 8'(err_overrun), 8'h01);
      wait_idle(n);
      bus_read(1'b0, rd);
      check8("busy_read_no_step", rd, 8'h40);

      // Gap addresses and CGRAM mode discard data
      do_write(1'b0, 8'hA8);
      do_write(1'b1, 8'h77);
      bus_read(1'b0, rd);
      check8("gap_step", rd, 8'h29);
      check_ram("gap_ram40", 40, 8'h5A);
      do_write(1'b0, 8'h85);
      do_write(1'b0, 8'h40);
      do_write(1'b1, 8'h99);
      check_ram("cgram_discard", 5, 8'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
